// File: rtl/multicycle_control_unit_if.sv
// multicycle_control_unit_if: shared memory port handshake between the control unit and memory
interface multicycle_control_unit_if;
  logic mem_req, mem_we, mem_unsigned, addr_sel, mem_ready;
  logic [1:0] mem_size;
  modport master(output mem_req, mem_we, mem_size, mem_unsigned, addr_sel, input mem_ready);
  modport slave(input mem_req, mem_we, mem_size, mem_unsigned, addr_sel, output mem_ready);
endinterface

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: RV32I FETCH/DECODE/EXEC/MEM/WB sequencer with memory wait timeout
module multicycle_control_unit #(
  parameter int TIMEOUT = 15,
  parameter int CNT_W = 8,
  parameter bit RD0_GATE = 1,
  parameter bit TRAP_ON_ILLEGAL = 1
)(
  input  logic clk,
  input  logic rst_n,
  input  logic [31:0] instr,
  input  logic br_taken,
  input  logic trap_clr,
  multicycle_control_unit_if.master mem,
  output logic ir_wen,
  output logic pc_wen,
  output logic [2:0] pc_sel,
  output logic reg_wen,
  output logic [1:0] wb_sel,
  output logic alu_a_sel,
  output logic alu_b_sel,
  output logic [2:0] imm_type,
  output logic [3:0] alu_sel,
  output logic trap,
  output logic [1:0] trap_cause,
  output logic busy
);
  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, TRAP} state_t;
  typedef enum logic [2:0] {C_NOP, C_ALU, C_BR, C_LD, C_ST, C_JAL, C_JALR} cls_t;
  typedef struct packed {
    cls_t cls;
    logic [3:0] alu;
    logic a, b;
    logic [2:0] imm;
    logic [1:0] wb;
    logic [2:0] f3;
    logic rd0;
  } dec_t;
  state_t st, st_n;
  dec_t d, dd;
  logic ill, to, unused;
  logic [CNT_W-1:0] cnt;
  logic [1:0] cause_n;
  logic [6:0] op;
  logic [2:0] f3;
  logic f7;
  assign op = instr[6:0];
  assign f3 = instr[14:12];
  assign f7 = instr[30];
  assign unused = ^{instr[31], instr[29:15]};
  assign to = cnt == CNT_W'(TIMEOUT);
  always_comb begin
    dd = '0;
    dd.f3 = f3;
    dd.rd0 = instr[11:7] == 5'd0;
    ill = 1'b0;
    case (op)
      7'b0110111: begin dd.cls = C_ALU; dd.imm = 3'd3; dd.b = 1'b1; dd.wb = 2'b11; end
      7'b0010111: begin dd.cls = C_ALU; dd.imm = 3'd3; dd.a = 1'b1; dd.b = 1'b1; end
      7'b1101111: begin dd.cls = C_JAL; dd.imm = 3'd4; dd.a = 1'b1; dd.b = 1'b1; dd.wb = 2'b10; end
      7'b1100111: begin dd.cls = C_JALR; dd.b = 1'b1; dd.wb = 2'b10; ill = f3 != 3'd0; end
      7'b1100011: begin dd.cls = C_BR; dd.imm = 3'd2; dd.alu = 4'b0001; ill = f3[2:1] == 2'b01; end
      7'b0000011: begin dd.cls = C_LD; dd.b = 1'b1; dd.wb = 2'b01; ill = f3 == 3'b011 || f3[2:1] == 2'b11; end
      7'b0100011: begin dd.cls = C_ST; dd.imm = 3'd1; dd.b = 1'b1; ill = f3[2] || f3[1:0] == 2'b11; end
      7'b0010011: begin
        dd.cls = C_ALU;
        dd.b = 1'b1;
        dd.alu = {f3[0], f3[1], f3[2], f3 == 3'b101 && f7};
        ill = f3 == 3'b001 && f7;
      end
      7'b0110011: begin
        dd.cls = C_ALU;
        dd.alu = {f3[0], f3[1], f3[2], f7};
        ill = f7 && f3 != 3'b000 && f3 != 3'b101;
      end
      7'b0001111, 7'b1110011: dd.cls = C_NOP;
      default: ill = 1'b1;
    endcase
    if (ill) dd.cls = C_NOP;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st <= FETCH;
      cnt <= '0;
      d <= '0;
      trap_cause <= 2'b00;
    end else begin
      st <= st_n;
      cnt <= st_n != st ? '0 : to ? cnt : cnt + CNT_W'(1);
      if (st == DECODE) d <= dd;
      trap_cause <= cause_n;
    end
  always_comb begin
    st_n = st;
    cause_n = trap_cause;
    mem.mem_req = 1'b0;
    mem.mem_we = 1'b0;
    mem.mem_size = 2'b00;
    mem.mem_unsigned = 1'b0;
    mem.addr_sel = 1'b0;
    ir_wen = 1'b0;
    pc_wen = 1'b0;
    pc_sel = 3'b000;
    reg_wen = 1'b0;
    wb_sel = 2'b00;
    alu_a_sel = 1'b0;
    alu_b_sel = 1'b0;
    imm_type = 3'b000;
    alu_sel = 4'b0000;
    trap = st == TRAP;
    busy = st != TRAP;
    if (rst_n && (st == EXEC || st == MEM || st == WB)) begin
      alu_sel = d.alu;
      alu_a_sel = d.a;
      alu_b_sel = d.b;
      imm_type = d.imm;
    end
    if (rst_n)
      case (st)
        FETCH: begin
          mem.mem_req = 1'b1;
          mem.mem_size = 2'b10;
          ir_wen = mem.mem_ready;
          st_n = mem.mem_ready ? DECODE : to ? TRAP : FETCH;
          cause_n = !mem.mem_ready && to ? 2'b10 : cause_n;
        end
        DECODE: begin
          st_n = ill && TRAP_ON_ILLEGAL ? TRAP : EXEC;
          cause_n = ill && TRAP_ON_ILLEGAL ? 2'b01 : cause_n;
        end
        EXEC: begin
          pc_wen = d.cls == C_BR;
          pc_sel = d.cls == C_BR && br_taken ? 3'b001 : 3'b000;
          st_n = d.cls == C_BR ? FETCH : d.cls == C_LD || d.cls == C_ST ? MEM : WB;
        end
        MEM: begin
          mem.mem_req = 1'b1;
          mem.addr_sel = 1'b1;
          mem.mem_we = d.cls == C_ST;
          mem.mem_size = d.f3[1:0];
          mem.mem_unsigned = d.cls == C_LD && d.f3[2];
          pc_wen = mem.mem_ready && d.cls == C_ST;
          st_n = mem.mem_ready ? (d.cls == C_ST ? FETCH : WB) : to ? TRAP : MEM;
          cause_n = !mem.mem_ready && to ? 2'b11 : cause_n;
        end
        WB: begin
          reg_wen = d.cls != C_NOP && !(RD0_GATE && d.rd0);
          wb_sel = d.wb;
          pc_wen = 1'b1;
          pc_sel = d.cls == C_JAL ? 3'b011 : d.cls == C_JALR ? 3'b010 : 3'b000;
          st_n = FETCH;
        end
        TRAP: begin
          pc_wen = trap_clr;
          pc_sel = trap_clr ? 3'b100 : 3'b000;
          cause_n = trap_clr ? 2'b00 : cause_n;
          st_n = trap_clr ? FETCH : TRAP;
        end
        default: st_n = FETCH;
      endcase
  end
endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb_multicycle_control_unit: cycle-by-cycle vector table against hand-derived control outputs
module tb_multicycle_control_unit;
  typedef struct packed {
    logic req, we;
    logic [1:0] size;
    logic uns, asel, ir, pcw;
    logic [2:0] pcs;
    logic rw;
    logic [1:0] wb;
    logic a, b;
    logic [2:0] imm;
    logic [3:0] alu;
    logic tr;
    logic [1:0] cause;
    logic busy;
  } out_t;
  typedef struct {
    logic r;
    logic [31:0] i;
    logic rd, br, cl, two;
    out_t e;
  } vec_t;
  localparam logic [31:0] ADDI = 32'h00500093, LW = 32'h0000A103, BEQ = 32'h00000463,
    SRA = 32'h4020D1B3, ADD0 = 32'h00208033, JAL = 32'h008000EF, LUI = 32'h123452B7,
    SW = 32'h0020A023, LBU = 32'h0000C103, ILL = 32'hFFFFFFFF;
  vec_t v[$];
  logic clk = 0, rst_n = 0, br_taken = 0, trap_clr = 0, mem_ready = 0, grp2 = 0;
  logic [31:0] instr = 0;
  int n_run = 0, n_fail = 0;
  logic ir[2], pw[2], rw[2], as[2], bs[2], tr[2], bz[2];
  logic [2:0] ps[2], it[2];
  logic [1:0] wb[2], tc[2];
  logic [3:0] al[2];
  out_t a1, a2, got, F, FW, DZ, NOPWB;
  always #5 clk = ~clk;
  multicycle_control_unit_if m1(), m2();
  assign m1.mem_ready = mem_ready;
  assign m2.mem_ready = mem_ready;
  multicycle_control_unit dut (.clk(clk), .rst_n(rst_n), .instr(instr), .br_taken(br_taken),
    .trap_clr(trap_clr), .mem(m1), .ir_wen(ir[0]), .pc_wen(pw[0]), .pc_sel(ps[0]),
    .reg_wen(rw[0]), .wb_sel(wb[0]), .alu_a_sel(as[0]), .alu_b_sel(bs[0]), .imm_type(it[0]),
    .alu_sel(al[0]), .trap(tr[0]), .trap_cause(tc[0]), .busy(bz[0]));
  multicycle_control_unit #(.TRAP_ON_ILLEGAL(0)) dut2 (.clk(clk), .rst_n(rst_n), .instr(instr),
    .br_taken(br_taken), .trap_clr(trap_clr), .mem(m2), .ir_wen(ir[1]), .pc_wen(pw[1]),
    .pc_sel(ps[1]), .reg_wen(rw[1]), .wb_sel(wb[1]), .alu_a_sel(as[1]), .alu_b_sel(bs[1]),
    .imm_type(it[1]), .alu_sel(al[1]), .trap(tr[1]), .trap_cause(tc[1]), .busy(bz[1]));
  assign a1 = {m1.mem_req, m1.mem_we, m1.mem_size, m1.mem_unsigned, m1.addr_sel, ir[0], pw[0],
    ps[0], rw[0], wb[0], as[0], bs[0], it[0], al[0], tr[0], tc[0], bz[0]};
  assign a2 = {m2.mem_req, m2.mem_we, m2.mem_size, m2.mem_unsigned, m2.addr_sel, ir[1], pw[1],
    ps[1], rw[1], wb[1], as[1], bs[1], it[1], al[1], tr[1], tc[1], bz[1]};
  function automatic out_t o(int req, we, size, uns, asel, irw, pcw, pcs, rwn, wbs, a, b, imm,
    alu, trp, cause, bsy);
    o = {1'(req), 1'(we), 2'(size), 1'(uns), 1'(asel), 1'(irw), 1'(pcw), 3'(pcs), 1'(rwn),
      2'(wbs), 1'(a), 1'(b), 3'(imm), 4'(alu), 1'(trp), 2'(cause), 1'(bsy)};
  endfunction
  task automatic vec(int r, logic [31:0] i, int rd, int br, int cl, out_t e);
    vec_t x;
    x.r = 1'(r);
    x.i = i;
    x.rd = 1'(rd);
    x.br = 1'(br);
    x.cl = 1'(cl);
    x.two = grp2;
    x.e = e;
    v.push_back(x);
  endtask
  task automatic pre(logic [31:0] i);
    vec(1, i, 1, 0, 0, F);
    vec(1, i, 1, 0, 0, DZ);
  endtask
  task automatic chk(string tag, int k, out_t g, out_t e, logic two, logic [31:0] i);
    if (g !== e) begin
      n_fail++;
      $display("FAIL %s vec%0d (dut%0d instr %h): got %h want %h", tag, k, two ? 2 : 1, i, g, e);
    end
  endtask
  initial begin
    F = o(1,0,2,0,0,1,0,0,0,0,0,0,0,0,0,0,1);
    FW = o(1,0,2,0,0,0,0,0,0,0,0,0,0,0,0,0,1);
    DZ = o(0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,1);
    NOPWB = o(0,0,0,0,0,0,1,0,0,0,0,0,0,0,0,0,1);
    vec(0, ADDI, 1, 0, 0, DZ);
    pre(ADDI);
    vec(1, ADDI, 1, 0, 0, o(0,0,0,0,0,0,0,0,0,0,0,1,0,0,0,0,1));
    vec(1, ADDI, 1, 0, 0, o(0,0,0,0,0,0,1,0,1,0,0,1,0,0,0,0,1));
    pre(LW);
    vec(1, LW, 0, 0, 0, o(0,0,0,0,0,0,0,0,0,0,0,1,0,0,0,0,1));
    for (int k = 0; k < 3; k++) vec(1, LW, 0, 0, 0, o(1,0,2,0,1,0,0,0,0,0,0,1,0,0,0,0,1));
    vec(1, LW, 1, 0, 0, o(1,0,2,0,1,0,0,0,0,0,0,1,0,0,0,0,1));
    vec(1, LW, 1, 0, 0, o(0,0,0,0,0,0,1,0,1,1,0,1,0,0,0,0,1));
    pre(BEQ);
    vec(1, BEQ, 1, 1, 0, o(0,0,0,0,0,0,1,1,0,0,0,0,2,1,0,0,1));
    pre(BEQ);
    vec(1, BEQ, 1, 0, 0, o(0,0,0,0,0,0,1,0,0,0,0,0,2,1,0,0,1));
    pre(SRA);
    vec(1, SRA, 1, 0, 0, o(0,0,0,0,0,0,0,0,0,0,0,0,0,11,0,0,1));
    vec(1, SRA, 1, 0, 0, o(0,0,0,0,0,0,1,0,1,0,0,0,0,11,0,0,1));
    pre(ADD0);
    vec(1, ADD0, 1, 0, 0, DZ);
    vec(1, ADD0, 1, 0, 0, NOPWB);
    pre(JAL);
    vec(1, JAL, 1, 0, 0, o(0,0,0,0,0,0,0,0,0,0,1,1,4,0,0,0,1));
    vec(1, JAL, 1, 0, 0, o(0,0,0,0,0,0,1,3,1,2,1,1,4,0,0,0,1));
    pre(LUI);
    vec(1, LUI, 1, 0, 0, o(0,0,0,0,0,0,0,0,0,0,0,1,3,0,0,0,1));
    vec(1, LUI, 1, 0, 0, o(0,0,0,0,0,0,1,0,1,3,0,1,3,0,0,0,1));
    pre(SW);
    vec(1, SW, 1, 0, 0, o(0,0,0,0,0,0,0,0,0,0,0,1,1,0,0,0,1));
    vec(1, SW, 1, 0, 0, o(1,1,2,0,1,0,1,0,0,0,0,1,1,0,0,0,1));
    for (int k = 0; k < 16; k++) vec(1, ADDI, 0, 0, 0, FW);
    vec(1, ADDI, 0, 0, 0, o(0,0,0,0,0,0,0,0,0,0,0,0,0,0,1,2,0));
    vec(1, ADDI, 0, 0, 1, o(0,0,0,0,0,0,1,4,0,0,0,0,0,0,1,2,0));
    pre(ILL);
    vec(1, ILL, 1, 0, 0, o(0,0,0,0,0,0,0,0,0,0,0,0,0,0,1,1,0));
    vec(1, ILL, 1, 0, 1, o(0,0,0,0,0,0,1,4,0,0,0,0,0,0,1,1,0));
    pre(LBU);
    vec(1, LBU, 0, 0, 0, o(0,0,0,0,0,0,0,0,0,0,0,1,0,0,0,0,1));
    for (int k = 0; k < 16; k++) vec(1, LBU, 0, 0, 0, o(1,0,0,1,1,0,0,0,0,0,0,1,0,0,0,0,1));
    vec(1, LBU, 0, 0, 0, o(0,0,0,0,0,0,0,0,0,0,0,0,0,0,1,3,0));
    vec(1, LBU, 0, 0, 1, o(0,0,0,0,0,0,1,4,0,0,0,0,0,0,1,3,0));
    pre(SW);
    vec(1, SW, 0, 0, 0, o(0,0,0,0,0,0,0,0,0,0,0,1,1,0,0,0,1));
    vec(1, SW, 0, 0, 0, o(1,1,2,0,1,0,0,0,0,0,0,1,1,0,0,0,1));
    vec(0, SW, 1, 0, 0, DZ);
    pre(SW);
    vec(1, SW, 1, 0, 0, o(0,0,0,0,0,0,0,0,0,0,0,1,1,0,0,0,1));
    vec(1, SW, 1, 0, 0, o(1,1,2,0,1,0,1,0,0,0,0,1,1,0,0,0,1));
    vec(1, SW, 1, 0, 0, F);
    grp2 = 1;
    vec(0, ILL, 1, 0, 0, DZ);
    pre(ILL);
    vec(1, ILL, 1, 0, 0, DZ);
    vec(1, ILL, 1, 0, 0, NOPWB);
    vec(1, ILL, 1, 0, 0, F);
    foreach (v[k]) begin
      @(posedge clk);
      #1;
      rst_n = v[k].r;
      instr = v[k].i;
      mem_ready = v[k].rd;
      br_taken = v[k].br;
      trap_clr = v[k].cl;
      @(negedge clk);
      got = v[k].two ? a2 : a1;
      n_run++;
      if (!v[k].r) chk("reset", k, got, v[k].e, v[k].two, v[k].i);
      else if (v[k].e.tr && v[k].e.cause[1]) chk("timeout", k, got, v[k].e, v[k].two, v[k].i);
      else chk("vec", k, got, v[k].e, v[k].two, v[k].i);
    end
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
Parametrised multi-cycle successor to the single-cycle RV32I decoder. Sequences every RV32I instruction through an FSM: FETCH -> DECODE -> EXEC -> MEM -> WB. Memory accesses use a req/ready handshake with a wait-cycle timeout. Sits between the instruction register, register file, ALU, PC register and the shared memory port. Emits per-state enables plus the same ALU select encoding the datapath ALU already uses.

Parameters:
TIMEOUT, 15, max mem_ready wait cycles per access before trapping (1..255)
CNT_W, 8, width of the wait counter (must hold TIMEOUT)
RD0_GATE, 1, 1 = suppress reg_wen when instr[11:7]==0
TRAP_ON_ILLEGAL, 1, 1 = unknown opcode/funct goes to TRAP; 0 = executed as NOP

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
instr  in  32  instruction register contents (valid from DECODE onward)
br_taken  in  1  branch comparator result, sampled in EXEC
mem_ready  in  1  memory accepts/completes the current request this cycle
trap_clr  in  1  leave TRAP, sampled in TRAP only
mem_req  out  1  memory request
mem_we  out  1  1 = store
mem_size  out  2  00 byte, 01 half, 10 word
mem_unsigned  out  1  zero-extend load data (lbu/lhu)
addr_sel  out  1  0 = PC drives memory address, 1 = ALU result
ir_wen  out  1  load instruction register
pc_wen  out  1  update PC
pc_sel  out  3  000 pc+4, 001 branch target, 010 jalr target (LSB cleared), 011 jal target, 100 trap vector
reg_wen  out  1  register file write
wb_sel  out  2  00 ALU, 01 load data, 10 pc+4, 11 immediate (lui)
alu_a_sel  out  1  0 = rs1, 1 = PC
alu_b_sel  out  1  0 = rs2, 1 = immediate
imm_type  out  3  000 I, 001 S, 010 B, 011 U, 100 J
alu_sel  out  4  ADD 0000, SUB 0001, SLL 1000, SLT 0100, SLTU 1100, XOR 0010, SRL 1010, SRA 1011, OR 0110, AND 1110
trap  out  1  FSM in TRAP
trap_cause  out  2  00 none, 01 illegal instruction, 10 fetch timeout, 11 data timeout
busy  out  1  high in every state except TRAP

Behaviour:
- Reset (async, rst_n=0): state=FETCH; wait counter=0; decode register cleared; trap_cause=00. While in reset all outputs are 0 except busy=1. Asserting reset mid-access drops mem_req immediately; no partial write-back.
- Decode: combinational on instr opcode/funct3/funct7[5]. Class and control fields are registered at the end of DECODE and held until the next DECODE.
- FETCH:
  - mem_req=1, mem_we=0, mem_size=10, addr_sel=0.
  - If mem_ready=1: ir_wen=1 in that cycle, counter cleared, next state DECODE.
  - Otherwise the counter increments. When the counter equals TIMEOUT and mem_ready=0, next state TRAP with cause 10.
- DECODE: 1 cycle. Illegal encoding with TRAP_ON_ILLEGAL=1 goes to TRAP with cause 01. Otherwise next state EXEC.
- EXEC: 1 cycle. alu_sel, alu_a_sel, alu_b_sel and imm_type are driven per instruction. Next state by class:
  - Branch: pc_wen=1; pc_sel=001 if br_taken else 000; ALU SUB; next FETCH.
  - Load/store: ALU ADD, imm I or S; next MEM.
  - All others: next WB.
- MEM:
  - mem_req=1, addr_sel=1, mem_we=store, mem_size from funct3.
  - Wait and timeout rules as in FETCH; timeout cause is 11.
  - On mem_ready: a store does pc_wen=1, pc_sel=000, next FETCH; a load goes to WB.
- WB: 1 cycle.
  - reg_wen=1, gated by RD0_GATE.
  - wb_sel: loads 01, jal/jalr 10, lui 11, all others 00.
  - pc_wen=1 with pc_sel 011 (jal), 010 (jalr) or 000 (others); next FETCH.
- TRAP: trap=1, busy=0, no mem_req, no writes. trap_clr=1 gives pc_wen=1, pc_sel=100, cause cleared, next FETCH.
- Latency with zero memory wait (mem_ready=1 in the request cycle): branch 3, store 4, ALU/jump/lui/auipc 4, load 5 cycles. Each wait cycle adds 1.
- Counter never wraps: it saturates at TIMEOUT and is cleared on every state change.
- Enables (pc_wen, ir_wen, reg_wen) are single-cycle pulses, never held across states.

Test Plan:
- Reset release with mem_ready=1, instr=0x00500093 (addi x1,x0,5) -> ir_wen at cycle 1; at cycle 4 WB: reg_wen=1, wb_sel=00, alu_sel=0000, alu_b_sel=1; pc_wen=1, pc_sel=000; back in FETCH at cycle 5.
- lw 0x0000A103 with mem_ready low for 3 MEM cycles -> mem_req held 4 cycles with addr_sel=1, mem_size=10; WB wb_sel=01; total 8 cycles.
- beq 0x00000463, br_taken=1 then 0 -> EXEC pc_sel=001 then 000; no reg_wen; 3 cycles each.
- Fetch with mem_ready=0 for TIMEOUT+1 cycles -> TRAP, trap=1, trap_cause=10, busy=0; trap_clr -> pc_sel=100, pc_wen=1, then FETCH.
- instr=0xFFFFFFFF -> TRAP cause 01 after DECODE; with TRAP_ON_ILLEGAL=0 no writes and pc+4. add x0,x1,x2 -> reg_wen=0 when RD0_GATE=1.
- rst_n pulsed low mid-MEM of sw -> mem_req drops immediately; no pc_wen; FETCH on release.
